// File: rtl/dsp_path_sequencer_pkg.sv
// Shared definitions for the dsp output-path sequencer.
//   - path encodings carried on selector / active_sel
//   - sequencer state encoding (also exported for observation)
//   - default fade, settle and debounce constants
package dsp_path_sequencer_pkg;

   localparam logic [1:0] PATH_DRY     = 2'b00;
   localparam logic [1:0] PATH_FIR     = 2'b01;
   localparam logic [1:0] PATH_ECHO    = 2'b10;
   localparam logic [1:0] PATH_ILLEGAL = 2'b11;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FADE_OUT = 2'd1,
      SETTLE   = 2'd2,
      FADE_IN  = 2'd3
   } state_t;

   localparam int DEFAULT_WIDTH         = 16;
   localparam int DEFAULT_FADE_LOG2     = 6;
   localparam int DEFAULT_SETTLE_CYCLES = 16;
   localparam int DEFAULT_STABLE_CNT    = 4;

   // True for the three routable paths; 11 is never a valid request.
   function automatic logic is_legal_path(input logic [1:0] sel);
      return sel != PATH_ILLEGAL;
   endfunction

endpackage

// File: rtl/dsp_path_sequencer_if.sv
// Bus between the sample sources and the path sequencer.
// All streams are free-running, one sample per sample_clock edge; there is
// no valid/ready flow control, every sample present at an edge is consumed.
//   selector      : requested path (master -> sequencer)
//   dry/fir/echo  : candidate sample streams (master -> sequencer)
//   output_sample : gain-scaled sample of the active path (sequencer -> master)
//   active_sel    : path currently routed to output_sample
//   busy          : sequencer is not in IDLE
//   state         : sequencer state, exported for observation
interface dsp_path_sequencer_if
   import dsp_path_sequencer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic [1:0]       selector;
   logic [WIDTH-1:0] dry_sample;
   logic [WIDTH-1:0] fir_sample;
   logic [WIDTH-1:0] echo_sample;
   logic [WIDTH-1:0] output_sample;
   logic [1:0]       active_sel;
   logic             busy;
   state_t           state;

   modport master (
      output selector, dry_sample, fir_sample, echo_sample,
      input  output_sample, active_sel, busy, state
   );

   modport slave (
      input  selector, dry_sample, fir_sample, echo_sample,
      output output_sample, active_sel, busy, state
   );
endinterface

// File: rtl/dsp_gain_scaler.sv
// Registered gain stage: signed sample times unsigned gain, arithmetic shift
// right by SHIFT (floor rounding), truncated to WIDTH.
// With gain == 2^SHIFT the output equals the input exactly.
//   clk, rst_n  : clock, asynchronous active-low reset (output clears to 0)
//   sample_in   : two's complement sample
//   gain        : unsigned gain, 2^SHIFT is unity
//   sample_out  : scaled sample, one clock after sample_in/gain
module dsp_gain_scaler #(
   parameter int WIDTH     = 16,
   parameter int GAIN_BITS = 7,
   parameter int SHIFT     = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     sample_in,
   input  logic [GAIN_BITS-1:0] gain,
   output logic [WIDTH-1:0]     sample_out
);
   localparam int PW = WIDTH + GAIN_BITS + 1;

   logic signed [PW-1:0] sample_ext;
   logic signed [PW-1:0] gain_ext;
   logic signed [PW-1:0] product;
   logic                 unused_product_bits;

   // Gain is zero-extended before the signed multiply so it never reads negative.
   assign sample_ext = PW'($signed(sample_in));
   assign gain_ext   = PW'($signed({1'b0, gain}));
   assign product    = sample_ext * gain_ext;

   // Taking bits [SHIFT +: WIDTH] is the arithmetic shift plus truncation.
   assign unused_product_bits = ^{product[PW-1:SHIFT+WIDTH], product[SHIFT-1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_out <= '0;
      end else begin
         sample_out <= product[SHIFT +: WIDTH];
      end
   end
endmodule

// File: rtl/dsp_path_sequencer.sv
// Click-free selector for the dry / FIR / echo output streams.
// A debounced path request fades the current path out, switches the mux,
// holds zero gain while the new path's pipeline settles, then fades in.
// A reversed request mid-fade turns the fade around without a gain jump.
//   sample_clock : sample-rate clock
//   reset        : asynchronous active-low reset
//   bus          : selector and sample inputs; scaled output, active_sel,
//                  busy and state outputs
module dsp_path_sequencer
   import dsp_path_sequencer_pkg::*;
#(
   parameter int WIDTH         = DEFAULT_WIDTH,
   parameter int FADE_LOG2     = DEFAULT_FADE_LOG2,
   parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
   parameter int STABLE_CNT    = DEFAULT_STABLE_CNT
) (
   input logic                 sample_clock,
   input logic                 reset,
   dsp_path_sequencer_if.slave bus
);
   localparam int GW = FADE_LOG2 + 1;
   localparam logic [GW-1:0] GAIN_FULL = GW'(2 ** FADE_LOG2);
   localparam logic [GW-1:0] GAIN_ONE  = GW'(1);

   localparam int CW = $clog2(STABLE_CNT + 1);
   localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CNT);

   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   // ---------------- selector debounce ----------------
   logic [1:0]    prev_sel;
   logic [CW-1:0] stable_cnt;
   logic [CW-1:0] stable_cnt_next;
   logic          accept;
   logic [1:0]    target;
   logic [1:0]    target_next;

   // A request is taken on the edge that sees the STABLE_CNT-th identical
   // sample, so the updated count is what gets compared.
   always_comb begin
      stable_cnt_next = stable_cnt;
      if (bus.selector != prev_sel) begin
         stable_cnt_next = CW'(1);
      end else if (stable_cnt != STABLE_MAX) begin
         stable_cnt_next = stable_cnt + CW'(1);
      end
      accept      = (stable_cnt_next == STABLE_MAX) && is_legal_path(bus.selector)
                    && (bus.selector != target);
      target_next = accept ? bus.selector : target;
   end

   always_ff @(posedge sample_clock or negedge reset) begin
      if (!reset) begin
         prev_sel   <= PATH_DRY;
         stable_cnt <= '0;
      end else begin
         prev_sel   <= bus.selector;
         stable_cnt <= stable_cnt_next;
      end
   end

   // ---------------- sequencer FSM ----------------
   state_t        state;
   logic [GW-1:0] gain;
   logic [1:0]    active_sel;
   logic [SW-1:0] settle_cnt;
   logic          busy;

   // Decisions use target_next so a request accepted on this edge takes
   // effect immediately (including the switch at the bottom of a fade).
   always_ff @(posedge sample_clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         gain       <= GAIN_FULL;
         active_sel <= PATH_DRY;
         target     <= PATH_DRY;
         settle_cnt <= '0;
         busy       <= 1'b0;
      end else begin
         target <= target_next;
         case (state)
            IDLE: begin
               gain <= GAIN_FULL;
               if (target_next != active_sel) begin
                  state <= FADE_OUT;
                  busy  <= 1'b1;
               end
            end
            FADE_OUT: begin
               if (target_next == active_sel) begin
                  // Request reversed: climb back from the current gain.
                  state <= FADE_IN;
               end else if (gain <= GAIN_ONE) begin
                  gain       <= '0;
                  active_sel <= target_next;
                  settle_cnt <= '0;
                  state      <= SETTLE;
               end else begin
                  gain <= gain - GAIN_ONE;
               end
            end
            SETTLE: begin
               gain <= '0;
               if (settle_cnt == SETTLE_LAST) begin
                  state <= FADE_IN;
               end else begin
                  settle_cnt <= settle_cnt + SW'(1);
               end
            end
            FADE_IN: begin
               if (target_next != active_sel) begin
                  // New destination while fading in: head back down from here.
                  state <= FADE_OUT;
               end else if (gain >= GAIN_FULL - GAIN_ONE) begin
                  gain  <= GAIN_FULL;
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  gain <= gain + GAIN_ONE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // ---------------- datapath ----------------
   logic [WIDTH-1:0] path_sample;

   always_comb begin
      case (active_sel)
         PATH_FIR:  path_sample = bus.fir_sample;
         PATH_ECHO: path_sample = bus.echo_sample;
         default:   path_sample = bus.dry_sample;
      endcase
   end

   dsp_gain_scaler #(
      .WIDTH     (WIDTH),
      .GAIN_BITS (GW),
      .SHIFT     (FADE_LOG2)
   ) u_scaler (
      .clk        (sample_clock),
      .rst_n      (reset),
      .sample_in  (path_sample),
      .gain       (gain),
      .sample_out (bus.output_sample)
   );

   assign bus.active_sel = active_sel;
   assign bus.busy       = busy;
   assign bus.state      = state;
endmodule

// File: tb/tb_dsp_path_sequencer.sv
// Directed bench for dsp_path_sequencer: expected output samples are queued
// when the inputs for a clock are driven and compared one clock later.
module tb_dsp_path_sequencer
   import dsp_path_sequencer_pkg::*;
;
   localparam int WIDTH    = 16;
   localparam int FULL     = 64;
   localparam int STABLE   = 4;
   localparam int DRY_VAL  = 1000;
   localparam int FIR_VAL  = -2000;
   localparam int ECHO_VAL = -32768;

   logic sample_clock;
   logic reset;

   dsp_path_sequencer_if #(.WIDTH(WIDTH)) bus ();

   dsp_path_sequencer #(
      .WIDTH         (WIDTH),
      .FADE_LOG2     (6),
      .SETTLE_CYCLES (16),
      .STABLE_CNT    (STABLE)
   ) dut (
      .sample_clock (sample_clock),
      .reset        (reset),
      .bus          (bus)
   );

   // ---------------- clock ----------------
   initial sample_clock = 1'b0;
   always #5 sample_clock = ~sample_clock;

   // ---------------- scoreboard ----------------
   logic [WIDTH-1:0] exp_q[$];
   int               checks = 0;
   int               errors = 0;
   string            phase  = "init";
   int               g_e;
   state_t           s_e;
   logic [1:0]       a_e;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s %s: observed %0d, expected %0d", phase, tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge sample_clock);
      #1;
   endtask

   // floor(s * g / 64) with plain integer arithmetic
   function automatic int scale(input int s, input int g);
      int p;
      p = s * g;
      if (p >= 0) return p / FULL;
      return -((-p + FULL - 1) / FULL);
   endfunction

   function automatic int src_of(input logic [1:0] a);
      case (a)
         PATH_FIR:  return FIR_VAL;
         PATH_ECHO: return ECHO_VAL;
         default:   return DRY_VAL;
      endcase
   endfunction

   // Check current state/busy/active_sel, queue the output the next edge
   // must produce from gain g on path a, clock, then compare it.
   task automatic run_step(input int g, input state_t s, input logic [1:0] a);
      logic [WIDTH-1:0] e;
      chk("state", s_to_int(bus.state), s_to_int(s));
      chk("busy", {31'b0, bus.busy}, {31'b0, s != IDLE});
      chk("active_sel", {30'b0, bus.active_sel}, {30'b0, a});
      exp_q.push_back(WIDTH'(scale(src_of(a), g)));
      tick();
      e = exp_q.pop_front();
      chk("output_sample", $signed(bus.output_sample), $signed(e));
   endtask

   function automatic logic signed [31:0] s_to_int(input logic [1:0] s);
      return {30'b0, s};
   endfunction

   // Present a new selector value and clock through the debounce window.
   task automatic request(input logic [1:0] sel, input logic [1:0] cur);
      bus.selector = sel;
      repeat (STABLE) run_step(FULL, IDLE, cur);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset           = 1'b0;
      bus.selector    = PATH_FIR;
      bus.dry_sample  = 16'd1234;
      bus.fir_sample  = 16'd555;
      bus.echo_sample = 16'hFFF9;

      // Reset held with nonzero inputs.
      phase = "reset";
      repeat (3) tick();
      chk("output_sample", $signed(bus.output_sample), 0);
      chk("active_sel", {30'b0, bus.active_sel}, 0);
      chk("busy", {31'b0, bus.busy}, 0);
      chk("state", s_to_int(bus.state), s_to_int(IDLE));

      bus.selector    = PATH_DRY;
      bus.dry_sample  = WIDTH'(DRY_VAL);
      bus.fir_sample  = WIDTH'(FIR_VAL);
      bus.echo_sample = WIDTH'(ECHO_VAL);
      reset           = 1'b1;
      phase = "post_reset";
      repeat (3) run_step(FULL, IDLE, PATH_DRY);

      // Dry -> FIR full switch: 64 fade out, 16 settle, 64 fade in.
      phase = "dry_to_fir";
      request(PATH_FIR, PATH_DRY);
      for (int k = 0; k <= 146; k++) begin
         if (k <= 64)      g_e = FULL - k;
         else if (k <= 80) g_e = 0;
         else              g_e = (k - 80 > FULL) ? FULL : k - 80;
         s_e = (k < 64) ? FADE_OUT : (k < 80) ? SETTLE : (k < 144) ? FADE_IN : IDLE;
         a_e = (k < 64) ? PATH_DRY : PATH_FIR;
         run_step(g_e, s_e, a_e);
      end

      // Short glitch to echo, then illegal code held: nothing may change.
      phase = "glitch";
      bus.selector = PATH_ECHO;
      repeat (3) run_step(FULL, IDLE, PATH_FIR);
      bus.selector = PATH_FIR;
      repeat (7) run_step(FULL, IDLE, PATH_FIR);
      phase = "illegal";
      bus.selector = PATH_ILLEGAL;
      repeat (100) run_step(FULL, IDLE, PATH_FIR);
      bus.selector = PATH_FIR;
      repeat (6) run_step(FULL, IDLE, PATH_FIR);

      // Request dry, reverse back to FIR when gain is 40.
      phase = "reversal";
      request(PATH_DRY, PATH_FIR);
      for (int k = 0; k <= 52; k++) begin
         if (k == 21) bus.selector = PATH_FIR;
         if (k <= 24) g_e = FULL - k;
         else         g_e = (k + 15 > FULL) ? FULL : k + 15;
         s_e = (k <= 24) ? FADE_OUT : (k < 49) ? FADE_IN : IDLE;
         run_step(g_e, s_e, PATH_FIR);
      end

      // Request dry, retarget to echo while settling.
      phase = "retarget";
      request(PATH_DRY, PATH_FIR);
      for (int k = 0; k <= 165; k++) begin
         if (k == 66) bus.selector = PATH_ECHO;
         if (k <= 64)      g_e = FULL - k;
         else if (k <= 98) g_e = 0;
         else              g_e = (k - 98 > FULL) ? FULL : k - 98;
         if (k < 64)       s_e = FADE_OUT;
         else if (k < 80)  s_e = SETTLE;
         else if (k == 80) s_e = FADE_IN;
         else if (k == 81) s_e = FADE_OUT;
         else if (k < 98)  s_e = SETTLE;
         else if (k < 162) s_e = FADE_IN;
         else              s_e = IDLE;
         a_e = (k < 64) ? PATH_FIR : (k < 82) ? PATH_DRY : PATH_ECHO;
         run_step(g_e, s_e, a_e);
      end

      // Reset pulsed mid fade-out.
      phase = "mid_fade_reset";
      request(PATH_DRY, PATH_ECHO);
      for (int k = 0; k < 10; k++) run_step(FULL - k, FADE_OUT, PATH_ECHO);
      #2;
      reset = 1'b0;
      #1;
      chk("output_sample", $signed(bus.output_sample), 0);
      chk("active_sel", {30'b0, bus.active_sel}, 0);
      chk("busy", {31'b0, bus.busy}, 0);
      chk("state", s_to_int(bus.state), s_to_int(IDLE));
      tick();
      tick();
      chk("held_output", $signed(bus.output_sample), 0);
      reset = 1'b1;
      repeat (3) run_step(FULL, IDLE, PATH_DRY);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
